// File: rtl/burst_acc_pkg.sv
// Shared types and width/limit helpers for the burst accumulator.
// Saturating arithmetic is enabled by defining BURST_ACC_SAT_EN.
package burst_acc_pkg;

  typedef enum logic {
    IDLE,
    ACCUM
  } acc_state_t;

  function automatic int count_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  function automatic longint sat_max(input int acc_width);
    return (64'sd1 <<< (acc_width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int acc_width);
    return -(64'sd1 <<< (acc_width - 1));
  endfunction

endpackage

// File: rtl/lat_align.sv
// DEPTH-stage shift register that delays beat-framing flags so they line up
// with the registered multiplier product.
module lat_align #(
  parameter int DEPTH = 1,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] r_pipe;

  // NOTE: clocked state uses non-blocking assignments so every stage samples
  // the previous stage's pre-edge value; blocking here would collapse the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign dout = r_pipe[DEPTH-1];

endmodule

// File: rtl/burst_acc.sv
// Per-burst signed accumulator behind the multiplier, with a valid/ready
// result register. Define BURST_ACC_SAT_EN for saturating adds and dout_sat.
module burst_acc
  import burst_acc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MULT_LAT  = 1,
  parameter int MAX_BURST = 16,
  parameter int ACC_WIDTH = 2*WIDTH + 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  input  logic signed [2*WIDTH-1:0]            din_p,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [ACC_WIDTH-1:0]          dout_acc,
  output logic [$clog2(MAX_BURST+1)-1:0]       dout_count,
  output logic                                 dout_err_len,
  output logic                                 dout_sat,
  output logic                                 err_drop
);

  localparam int CW = count_w(MAX_BURST);

  logic [1:0] w_align;
  logic       w_a_valid, w_a_last;

  // Only a last flag that rides on a valid beat is carried down the line.
  lat_align #(.DEPTH(MULT_LAT), .W(2)) u_lat_align (
    .clk  (clk),
    .rst  (rst),
    .din  ({in_valid, in_valid & in_last}),
    .dout (w_align)
  );
  assign w_a_valid = w_align[1];
  assign w_a_last  = w_align[0];

  acc_state_t                  r_state, w_state_next;
  logic signed [ACC_WIDTH-1:0] r_acc, w_p_ext, w_base, w_sum;
  logic [CW-1:0]               r_count, w_cnt_next;
  logic                        w_complete;

  logic                        r_out_valid, r_err_len, r_err_drop;
  logic signed [ACC_WIDTH-1:0] r_dout_acc;
  logic [CW-1:0]               r_dout_count;

  assign w_p_ext = {{(ACC_WIDTH-2*WIDTH){din_p[2*WIDTH-1]}}, din_p};

`ifdef BURST_ACC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));
  logic signed [ACC_WIDTH:0] w_wide;
  logic                      w_clamp, w_sat_next, r_sat, r_dout_sat;
`endif

  // NOTE: every combinational output gets a default first, so no path
  // through this block can leave a value unassigned and infer a latch.
  always_comb begin
    w_base     = (r_state == ACCUM) ? r_acc : '0;
`ifdef BURST_ACC_SAT_EN
    // One guard bit exposes overflow; disagreement of the top two bits clamps.
    w_wide     = {w_base[ACC_WIDTH-1], w_base} + {w_p_ext[ACC_WIDTH-1], w_p_ext};
    w_sum      = w_wide[ACC_WIDTH-1:0];
    w_clamp    = 1'b0;
    if (w_wide[ACC_WIDTH] != w_wide[ACC_WIDTH-1]) begin
      w_clamp = 1'b1;
      w_sum   = w_wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end
    w_sat_next = ((r_state == ACCUM) ? r_sat : 1'b0) | w_clamp;
`else
    w_sum      = w_base + w_p_ext;
`endif
    w_cnt_next   = (r_state == ACCUM) ? r_count + 1'b1 : CW'(1);
    w_complete   = w_a_valid & (w_a_last | (w_cnt_next == CW'(MAX_BURST)));
    w_state_next = r_state;
    if (w_a_valid) w_state_next = w_complete ? IDLE : ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
`ifdef BURST_ACC_SAT_EN
      r_sat   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_a_valid) begin
        r_acc   <= w_sum;
        r_count <= w_cnt_next;
`ifdef BURST_ACC_SAT_EN
        r_sat   <= w_sat_next;
`endif
      end
    end
  end

  // A completion only lands if the register is free or being drained now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_dout_acc   <= '0;
      r_dout_count <= '0;
      r_err_len    <= 1'b0;
      r_err_drop   <= 1'b0;
`ifdef BURST_ACC_SAT_EN
      r_dout_sat   <= 1'b0;
`endif
    end else begin
      r_err_drop <= w_complete & r_out_valid & ~out_ready;
      if (w_complete && (!r_out_valid || out_ready)) begin
        r_out_valid  <= 1'b1;
        r_dout_acc   <= w_sum;
        r_dout_count <= w_cnt_next;
        r_err_len    <= ~w_a_last;
`ifdef BURST_ACC_SAT_EN
        r_dout_sat   <= w_sat_next;
`endif
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign dout_acc     = r_dout_acc;
  assign dout_count   = r_dout_count;
  assign dout_err_len = r_err_len;
  assign err_drop     = r_err_drop;
`ifdef BURST_ACC_SAT_EN
  assign dout_sat     = r_dout_sat;
`else
  assign dout_sat     = 1'b0;
`endif

endmodule

// File: tb/tb_burst_acc.sv
// Directed bench for burst_acc: three instances (default, MAX_BURST=4,
// ACC_WIDTH=16) share one operand stream through a one-cycle multiplier model.
module tb_burst_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic signed [7:0]  din_a = '0, din_b = '0;
  logic signed [15:0] din_p = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Registered multiplier, latency 1.
  always @(posedge clk) din_p <= din_a * din_b;

  logic               m_valid, m_err_len, m_sat, m_drop;
  logic signed [19:0] m_acc;
  logic [4:0]         m_count;
  logic               o_valid, o_err_len, o_sat, o_drop;
  logic signed [19:0] o_acc;
  logic [2:0]         o_count;
  logic               s_valid, s_err_len, s_sat, s_drop;
  logic signed [15:0] s_acc;
  logic [4:0]         s_count;

  burst_acc u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .din_p(din_p),
    .out_valid(m_valid), .out_ready(out_ready), .dout_acc(m_acc), .dout_count(m_count),
    .dout_err_len(m_err_len), .dout_sat(m_sat), .err_drop(m_drop)
  );

  burst_acc #(.MAX_BURST(4)) u_ovr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .din_p(din_p),
    .out_valid(o_valid), .out_ready(out_ready), .dout_acc(o_acc), .dout_count(o_count),
    .dout_err_len(o_err_len), .dout_sat(o_sat), .err_drop(o_drop)
  );

  burst_acc #(.ACC_WIDTH(16)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .din_p(din_p),
    .out_valid(s_valid), .out_ready(out_ready), .dout_acc(s_acc), .dout_count(s_count),
    .dout_err_len(s_err_len), .dout_sat(s_sat), .err_drop(s_drop)
  );

  task automatic drive(input int a, input int b, input logic v, input logic l);
    @(negedge clk);
    din_a = 8'(a); din_b = 8'(b); in_valid = v; in_last = l;
  endtask

  task automatic idle();
    drive(0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({m_valid, m_acc, m_count, m_err_len, m_sat, m_drop} !== '0) begin
      failures++;
      $display("FAIL reset_state got valid=%0b acc=%0d count=%0d err_len=%0b sat=%0b drop=%0b exp all 0",
               m_valid, m_acc, m_count, m_err_len, m_sat, m_drop);
    end
    rst = 1'b0;
    // Two beats then a reset mid-burst; the partial sum must be discarded.
    drive(1, 1, 1'b1, 1'b0);
    drive(2, 2, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_acc !== 0) begin
      failures++;
      $display("FAIL reset_midburst got valid=%0b acc=%0d exp valid=0 acc=0", m_valid, m_acc);
    end
    rst = 1'b0;
    drive(5, 5, 1'b1, 1'b1);
    idle();
    idle();
    checks++;
    if (m_valid !== 1'b1 || m_acc !== 25 || m_count !== 5'd1) begin
      failures++;
      $display("FAIL reset_then_single got valid=%0b acc=%0d count=%0d exp 1/25/1", m_valid, m_acc, m_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b0;
    drive(3, 4, 1'b1, 1'b0);
    drive(9, 9, 1'b0, 1'b1);   // last without valid is a gap, not a close
    drive(-2, 5, 1'b1, 1'b0);
    drive(7, 7, 1'b1, 1'b1);
    idle();
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early got valid=%0b exp 0", m_valid);
    end
    idle();
    checks++;
    if (m_valid !== 1'b1 || m_acc !== 51 || m_count !== 5'd3 || m_err_len !== 1'b0) begin
      failures++;
      $display("FAIL single_result got valid=%0b acc=%0d count=%0d err_len=%0b exp 1/51/3/0",
               m_valid, m_acc, m_count, m_err_len);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    drive(1, 1, 1'b1, 1'b1);
    drive(2, 2, 1'b1, 1'b0);
    drive(2, 2, 1'b1, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_acc !== 1 || m_count !== 5'd1) begin
      failures++;
      $display("FAIL b2b_first got valid=%0b acc=%0d count=%0d exp 1/1/1", m_valid, m_acc, m_count);
    end
    idle();
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got valid=%0b exp 0", m_valid);
    end
    idle();
    checks++;
    if (m_valid !== 1'b1 || m_acc !== 8 || m_count !== 5'd2 || m_drop !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got valid=%0b acc=%0d count=%0d drop=%0b exp 1/8/2/0",
               m_valid, m_acc, m_count, m_drop);
    end
    idle();
    checks++;
    if (m_valid !== 1'b0 || m_acc !== 8) begin
      failures++;
      $display("FAIL b2b_hold got valid=%0b acc=%0d exp 0/8", m_valid, m_acc);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(1, 1, 1'b1, 1'b0);
    drive(1, 1, 1'b1, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_acc !== 4 || o_count !== 3'd4 || o_err_len !== 1'b1) begin
      failures++;
      $display("FAIL overrun_forced got valid=%0b acc=%0d count=%0d err_len=%0b exp 1/4/4/1",
               o_valid, o_acc, o_count, o_err_len);
    end
    idle();
    idle();
    checks++;
    if (o_valid !== 1'b1 || o_acc !== 2 || o_count !== 3'd2 || o_err_len !== 1'b0) begin
      failures++;
      $display("FAIL overrun_tail got valid=%0b acc=%0d count=%0d err_len=%0b exp 1/2/2/0",
               o_valid, o_acc, o_count, o_err_len);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    drive(3, 3, 1'b1, 1'b1);
    drive(2, 1, 1'b1, 1'b0);
    drive(1, 1, 1'b1, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_acc !== 9) begin
      failures++;
      $display("FAIL bp_first got valid=%0b acc=%0d exp 1/9", m_valid, m_acc);
    end
    idle();
    checks++;
    if (m_drop !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_early_drop got drop=%0b exp 0", m_drop);
    end
    idle();
    checks++;
    if (m_drop !== 1'b1 || m_valid !== 1'b1 || m_acc !== 9 || m_count !== 5'd1) begin
      failures++;
      $display("FAIL bp_drop got drop=%0b valid=%0b acc=%0d count=%0d exp 1/1/9/1",
               m_drop, m_valid, m_acc, m_count);
    end
    idle();
    checks++;
    if (m_drop !== 1'b0 || m_acc !== 9) begin
      failures++;
      $display("FAIL bp_pulse_end got drop=%0b acc=%0d exp 0/9", m_drop, m_acc);
    end
    out_ready = 1'b1;
    idle();
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept got valid=%0b exp 0", m_valid);
    end
  endtask

  task automatic test_saturation();
    int          exp_acc;
    logic        exp_sat;
`ifdef BURST_ACC_SAT_EN
    exp_acc = 32767;  exp_sat = 1'b1;
`else
    exp_acc = -16384; exp_sat = 1'b0;
`endif
    do_reset();
    out_ready = 1'b1;
    drive(-128, -128, 1'b1, 1'b0);
    drive(-128, -128, 1'b1, 1'b0);
    drive(-128, -128, 1'b1, 1'b1);
    idle();
    idle();
    checks++;
    if (s_valid !== 1'b1 || s_acc !== exp_acc || s_sat !== exp_sat || s_count !== 5'd3) begin
      failures++;
      $display("FAIL sat_result got valid=%0b acc=%0d sat=%0b count=%0d exp 1/%0d/%0b/3",
               s_valid, s_acc, s_sat, s_count, exp_acc, exp_sat);
    end
    checks++;
    if (m_acc !== 49152 || m_sat !== 1'b0) begin
      failures++;
      $display("FAIL sat_wide_ref got acc=%0d sat=%0b exp 49152/0", m_acc, m_sat);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_backpressure();
    test_saturation();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/burst_acc.md
# burst_acc

Accumulates the signed product stream from the registered `mult` stage into one sum per TDM data burst. It sits directly downstream of the multiplier. Beat-framing flags launched alongside the operands are delay-aligned internally to the multiplier latency. Each burst closes on its last beat, or is forced closed on length overrun, and the sum and beat count are presented on a valid/ready output register.

## Interface
- `WIDTH`, 8: multiplier operand width; product width is 2*WIDTH.
- `MULT_LAT`, 1: multiplier latency in cycles, ≥1.
- `MAX_BURST`, 16: maximum beats per burst.
- `ACC_WIDTH`, 2*WIDTH+4: accumulator width, signed.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand beat valid, in the same cycle as `din_a`/`din_b` at the multiplier input.
- `in_last` in 1: final beat of burst, same timing as `in_valid`.
- `din_p` in 2*WIDTH: signed product from `mult.dout_p`.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer accepts the result.
- `dout_acc` out ACC_WIDTH: signed burst sum.
- `dout_count` out $clog2(MAX_BURST+1): beats in the burst.
- `dout_err_len` out 1: burst was force-closed at MAX_BURST.
- `dout_sat` out 1: saturation occurred. Only present with the macro; otherwise the port is tied 0.
- `err_drop` out 1: one-cycle pulse when a completed result is discarded.

## Operation
- `lat_align` delays `in_valid` and `in_last` by MULT_LAT cycles, giving `a_valid` and `a_last` aligned with `din_p`. Only `in_last` qualified by `in_valid` is honoured.
- FSM `IDLE`:
  - On `a_valid`, load `acc <= sext(din_p)` and `count <= 1`.
  - If `a_last` is also set, complete the burst immediately; otherwise go to `ACCUM`.
- FSM `ACCUM`:
  - On `a_valid`, set `acc <= acc + sext(din_p)` and `count++`.
  - If `a_last`, complete and go to `IDLE`.
  - If `count+1 == MAX_BURST` without `a_last`, complete with `err_len=1` and go to `IDLE`. Following beats start a new burst.
  - Cycles without `a_valid` hold state; gaps inside a burst are legal.
- Completion loads the output register: `out_valid=1`, plus `dout_acc`, `dout_count` and `dout_err_len`.
  - If the register is empty, or `out_valid & out_ready` in the same cycle, the new result loads and `out_valid` stays 1.
  - If `out_valid & !out_ready`, the new result is discarded, `err_drop` pulses, and the held result is unchanged.
- Accepting a result (`out_valid & out_ready`) with no new completion clears `out_valid`. The data outputs hold their last values.
- Arithmetic is two's complement. Without the macro, the accumulator wraps modulo 2^ACC_WIDTH.
- Reset, asynchronous at any time:
  - FSM returns to `IDLE`.
  - `acc`, `count`, the delay line and all outputs go to 0.
  - A partial burst and any in-flight beats are discarded.

## Timing
- Beat with `in_valid` at cycle t: its product is accumulated at edge t+MULT_LAT+1.
- Last beat at t: `out_valid` rises in cycle t+MULT_LAT+1.
- Back-to-back bursts are supported: a new first beat may directly follow a last beat, at full rate with no bubble.
- Minimum result spacing is 1 cycle, for single-beat bursts.
- Reset values: `out_valid` 0, `dout_acc` 0, `dout_count` 0, `dout_err_len` 0, `dout_sat` 0, `err_drop` 0.

## Configuration
- `BURST_ACC_SAT_EN` defined:
  - Each add clamps to +2^(ACC_WIDTH-1)-1 or −2^(ACC_WIDTH-1).
  - A sticky per-burst flag records any clamp and is output as `dout_sat`.
- Undefined: wrap-around arithmetic, and `dout_sat` is tied 0.

## Structure
- `burst_acc_pkg` holds:
  - `acc_state_t` enum (`IDLE`, `ACCUM`).
  - Count-width and saturation-limit localparam functions of ACC_WIDTH and MAX_BURST.
- Sub-module `lat_align` is a parameterised MULT_LAT-deep shift register with asynchronous reset, carrying {valid, last}.

## Test plan
- All cases use WIDTH=8 and MULT_LAT=1.
- Single burst: operand pairs (3,4), (−2,5), (7,7), last on the third → `dout_acc`=51, `count`=3, `out_valid` 2 cycles after the last beat.
- Back-to-back: burst (1,1) last, immediately followed by (2,2), (2,2) last, `out_ready`=1 → results 1/count 1, then 8/count 2, with no dropped beat.
- Overrun: MAX_BURST=4, 6 beats of (1,1) with no last → result 4 with `err_len`=1, then the next result is 2 for the remaining beats once a last arrives.
- Backpressure: `out_ready`=0 while a second burst completes → first result is held unchanged and `err_drop` pulses once.
- Saturation: with the macro, ACC_WIDTH=16, 3 beats of (−128,−128) → `dout_acc`=32767, `dout_sat`=1. Without the macro → wrapped value −16384.
- Reset: assert `rst` mid-burst after 2 beats, release, then send a one-beat burst (5,5) → output 25, count 1.
